square_ctrl: RTL and testbench
==============================

SQUARE_CTRL -- requirements
Module: square_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 2_000_000, the number of consecutive stable synchronized samples required to accept a button level change; legal range 2..2^24-1.
REQ-002 SHALL have port clk  input  1  sole system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port btn_en  input  1  raw, bouncy, asynchronous pause/run push-button, active-high.
REQ-005 SHALL have port btn_dir  input  1  raw, bouncy, asynchronous direction push-button, active-high.
REQ-006 SHALL have port en  output  1  run enable driven into rotating_square en.
REQ-007 SHALL have port cw  output  1  direction driven into rotating_square cw (1 = clockwise).
REQ-008 SHALL have port db_en  output  1  debounced level of btn_en.
REQ-009 SHALL have port db_dir  output  1  debounced level of btn_dir.
REQ-010 SHALL have port en_p  output  1  one-cycle pulse on each accepted btn_en press.
REQ-011 SHALL have port dir_p  output  1  one-cycle pulse on each accepted btn_dir press.

Function
REQ-012 Each button input SHALL pass through a 2-flop synchronizer; the second flop output (s) is the only value seen by the debouncer.
REQ-013 Each button SHALL have an independent debounce FSM with states LO, WAIT_HI, HI, WAIT_LO, and a counter of ceil(log2(DB_CYCLES+1)) bits.
REQ-014 LO: s=1 -> WAIT_HI with counter=1; s=0 -> stay.
REQ-015 WAIT_HI: s=0 -> LO with counter cleared; s=1 and counter=DB_CYCLES-1 -> HI; otherwise counter+1.
REQ-016 HI and WAIT_LO SHALL mirror REQ-014/015 with polarity inverted (HI -> WAIT_LO on s=0; WAIT_LO -> LO after DB_CYCLES consecutive s=0 samples; s=1 returns to HI).
REQ-017 db_en/db_dir SHALL be 1 exactly while the corresponding FSM is in HI or WAIT_LO.
REQ-018 On the edge an FSM enters HI from WAIT_HI, the corresponding pulse (en_p/dir_p) SHALL be 1 for exactly that one cycle; no pulse on release.
REQ-019 en SHALL toggle on the same edge en_p asserts; cw SHALL toggle on the same edge dir_p asserts; these are registered outputs with no combinational path from inputs.
REQ-020 Latency: a raw 0->1 step held stable SHALL raise db_*, pulse, and toggle on the (DB_CYCLES+2)th rising edge after the step is first sampled.
REQ-021 Glitches shorter than DB_CYCLES samples SHALL produce no change on any output.
REQ-022 Simultaneous accepted presses on both buttons SHALL assert both pulses and toggle both en and cw in the same cycle.
REQ-023 A button held indefinitely SHALL produce exactly one pulse and one toggle (no auto-repeat).
REQ-024 Counter SHALL never wrap; it is bounded by DB_CYCLES-1 by construction.

Reset
REQ-025 rst low SHALL immediately and asynchronously force: synchronizer flops 0, both FSMs LO, counters 0, en=1, cw=0, db_en=0, db_dir=0, en_p=0, dir_p=0.
REQ-026 Reset release SHALL be synchronous in effect: first state update on the first clk rising edge with rst high.
REQ-027 rst asserted mid-debounce (WAIT_HI) SHALL discard the pending press; a button still held after release SHALL be re-qualified from LO with full DB_CYCLES latency and then produce one pulse.

Verification (DB_CYCLES=4, 10 ns clk)
REQ-028 Reset: rst low 3 ns then high -> en=1, cw=0, db_*=0, pulses 0 immediately, before any clk edge.
REQ-029 Clean press: btn_dir 0->1 held 100 ns -> dir_p high one cycle on the 6th edge, cw 0->1, db_dir=1; en unchanged.
REQ-030 Bounce: btn_en toggling every 10 ns for 60 ns, then stable 1 -> exactly one en_p, en 1->0; no activity during the bounce.
REQ-031 Release and re-press: btn_en released 80 ns, pressed again 80 ns -> second en_p, en back to 1; no pulse on release.
REQ-032 Simultaneous: both buttons rise on the same edge and hold -> en_p and dir_p in the same cycle, en and cw both toggle.
REQ-033 Reset mid-debounce: rst pulsed low while btn_dir is in WAIT_HI with the button held -> cw stays 0 through reset, then one dir_p and cw=1 on the 6th edge after rst rises.

Source files
------------

// File: rtl/square_ctrl.sv
// square_ctrl: synchronizes and debounces the pause/run and direction
// push-buttons, then turns each accepted press into a one-cycle pulse and a
// toggle of the run-enable / clockwise controls for rotating_square.
module square_ctrl #(
  parameter int DB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_en,
  input  logic btn_dir,
  output logic en,
  output logic cw,
  output logic db_en,
  output logic db_dir,
  output logic en_p,
  output logic dir_p
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    LO      = 2'd0,
    WAIT_HI = 2'd1,
    HI      = 2'd2,
    WAIT_LO = 2'd3
  } db_state_t;

  // Bit/index 0 belongs to the pause/run button, 1 to the direction button.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  db_state_t     state_q [2];
  db_state_t     state_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0]    pulse_q, pulse_d;
  logic          en_q, en_d;
  logic          cw_q, cw_d;
  logic [1:0]    db_level;

  assign btn_raw = {btn_dir, btn_en};

  // Next-state logic: synchronizer shift, per-button debounce FSMs, press
  // pulses and the toggles they cause; the counter saturates at CNT_MAX
  // because reaching it always leaves the waiting state.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    pulse_d  = '0;
    db_level = '0;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        LO: begin
          if (sync2_q[i]) begin
            state_d[i] = WAIT_HI;
            cnt_d[i]   = CNT_ONE;
          end
        end
        WAIT_HI: begin
          if (!sync2_q[i]) begin
            state_d[i] = LO;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = HI;
            cnt_d[i]   = '0;
            pulse_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        HI: begin
          if (!sync2_q[i]) begin
            state_d[i] = WAIT_LO;
            cnt_d[i]   = CNT_ONE;
          end
        end
        WAIT_LO: begin
          if (sync2_q[i]) begin
            state_d[i] = HI;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = LO;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = LO;
          cnt_d[i]   = '0;
        end
      endcase
      db_level[i] = (state_q[i] == HI) || (state_q[i] == WAIT_LO);
    end
    en_d = en_q ^ pulse_d[0];
    cw_d = cw_q ^ pulse_d[1];
  end

  // State registers; reset drops everything to idle with the square running
  // counter-clockwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= LO;
        cnt_q[i]   <= '0;
      end
      pulse_q <= '0;
      en_q    <= 1'b1;
      cw_q    <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pulse_q <= pulse_d;
      en_q    <= en_d;
      cw_q    <= cw_d;
    end
  end

  assign en     = en_q;
  assign cw     = cw_q;
  assign db_en  = db_level[0];
  assign db_dir = db_level[1];
  assign en_p   = pulse_q[0];
  assign dir_p  = pulse_q[1];

endmodule

// File: tb/tb_square_ctrl.sv
// tb_square_ctrl: directed scenarios plus random bouncy buttons, checked
// against a behavioural model that accepts a level once DB consecutive
// synchronized samples disagree with the current debounced level.
module tb_square_ctrl;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_en = 1'b0;
  logic btn_dir = 1'b0;
  logic en, cw, db_en, db_dir, en_p, dir_p;

  int checks = 0;
  int errors = 0;

  square_ctrl #(.DB_CYCLES(DB)) dut (
    .clk(clk),
    .rst(rst),
    .btn_en(btn_en),
    .btn_dir(btn_dir),
    .en(en),
    .cw(cw),
    .db_en(db_en),
    .db_dir(db_dir),
    .en_p(en_p),
    .dir_p(dir_p)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Reference model: two-sample delay, then a run length of samples that
  // disagree with the accepted level; DB such samples flip the level.
  logic [1:0] m_p1, m_p2, m_lvl, m_pulse;
  int         m_run [2];
  logic       m_en, m_cw;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_p1    <= '0;
      m_p2    <= '0;
      m_lvl   <= '0;
      m_pulse <= '0;
      m_run[0] <= 0;
      m_run[1] <= 0;
      m_en    <= 1'b1;
      m_cw    <= 1'b0;
    end else begin
      m_p1 <= {btn_dir, btn_en};
      m_p2 <= m_p1;
      for (int i = 0; i < 2; i++) begin
        if (m_p2[i] == m_lvl[i]) begin
          m_run[i]   <= 0;
          m_pulse[i] <= 1'b0;
        end else if (m_run[i] == DB - 1) begin
          m_lvl[i]   <= m_p2[i];
          m_run[i]   <= 0;
          m_pulse[i] <= m_p2[i];
        end else begin
          m_run[i]   <= m_run[i] + 1;
          m_pulse[i] <= 1'b0;
        end
      end
      m_en <= m_en ^ (m_p2[0] & ~m_lvl[0] & (m_run[0] == DB - 1));
      m_cw <= m_cw ^ (m_p2[1] & ~m_lvl[1] & (m_run[1] == DB - 1));
    end
  end

  logic [5:0] dut_vec, mdl_vec;
  assign dut_vec = {en, cw, db_en, db_dir, en_p, dir_p};
  assign mdl_vec = {m_en, m_cw, m_lvl[0], m_lvl[1], m_pulse[0], m_pulse[1]};

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset_during got %b want %b", dut_vec, 6'b100000);
    end
    #2 rst = 1'b1;
    checks++;
    if (en !== 1'b1) begin errors++; $display("[TB] FAIL reset_en got %b want 1", en); end
    checks++;
    if (cw !== 1'b0) begin errors++; $display("[TB] FAIL reset_cw got %b want 0", cw); end
    checks++;
    if ({db_en, db_dir} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_db got %b want 00", {db_en, db_dir});
    end
    checks++;
    if ({en_p, dir_p} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_pulses got %b want 00", {en_p, dir_p});
    end
  endtask

  task automatic test_clean_press();
    logic cw0, en0;
    @(negedge clk);
    cw0 = cw;
    en0 = en;
    btn_dir = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (dir_p !== 1'(k == 6)) begin
        errors++; $display("[TB] FAIL clean_dir_p edge %0d got %b want %b", k, dir_p, k == 6);
      end
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("[TB] FAIL clean_model edge %0d got %b want %b", k, dut_vec, mdl_vec);
      end
    end
    checks++;
    if (cw !== ~cw0) begin errors++; $display("[TB] FAIL clean_cw got %b want %b", cw, ~cw0); end
    checks++;
    if (en !== en0) begin errors++; $display("[TB] FAIL clean_en got %b want %b", en, en0); end
    checks++;
    if (db_dir !== 1'b1) begin errors++; $display("[TB] FAIL clean_db_dir got %b want 1", db_dir); end
  endtask

  task automatic test_glitch();
    logic cw0;
    int pulses;
    btn_dir = 1'b0;
    wait_cycles(8);
    cw0 = cw;
    pulses = 0;
    btn_dir = 1'b1;
    for (int k = 0; k < 13; k++) begin
      if (k == DB - 1) btn_dir = 1'b0;
      @(posedge clk);
      @(negedge clk);
      pulses += int'(dir_p) + int'(en_p);
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("[TB] FAIL glitch_pulses got %0d want 0", pulses); end
    checks++;
    if ({cw, db_dir} !== {cw0, 1'b0}) begin
      errors++; $display("[TB] FAIL glitch_state got %b want %b", {cw, db_dir}, {cw0, 1'b0});
    end
  endtask

  task automatic test_bounce();
    logic en0;
    int pulses;
    en0 = en;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      btn_en = (k % 2 == 0);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({en_p, en, db_en} !== {1'b0, en0, 1'b0}) begin
        errors++; $display("[TB] FAIL bounce_quiet step %0d got %b want %b", k, {en_p, en, db_en}, {1'b0, en0, 1'b0});
      end
    end
    btn_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      pulses += int'(en_p);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("[TB] FAIL bounce_model step %0d got %b want %b", k, dut_vec, mdl_vec);
      end
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("[TB] FAIL bounce_pulses got %0d want 1", pulses); end
    checks++;
    if (en !== ~en0) begin errors++; $display("[TB] FAIL bounce_en got %b want %b", en, ~en0); end
  endtask

  task automatic test_release_repress();
    int pulses;
    pulses = 0;
    btn_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      pulses += int'(en_p);
    end
    checks++;
    if ({pulses != 0, db_en} !== 2'b00) begin
      errors++; $display("[TB] FAIL release_quiet got pulses %0d db_en %b want 0 0", pulses, db_en);
    end
    btn_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      pulses += int'(en_p);
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("[TB] FAIL repress_pulses got %0d want 1", pulses); end
    checks++;
    if (en !== 1'b1) begin errors++; $display("[TB] FAIL repress_en got %b want 1", en); end
  endtask

  task automatic test_back_to_back();
    logic en0, cw0;
    int extra;
    btn_en = 1'b0;
    btn_dir = 1'b0;
    wait_cycles(8);
    en0 = en;
    cw0 = cw;
    btn_en = 1'b1;
    btn_dir = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({en_p, dir_p} !== {2{1'(k == 6)}}) begin
        errors++; $display("[TB] FAIL simul_pulses edge %0d got %b want %b", k, {en_p, dir_p}, {2{1'(k == 6)}});
      end
    end
    checks++;
    if ({en, cw} !== {~en0, ~cw0}) begin
      errors++; $display("[TB] FAIL simul_toggle got %b want %b", {en, cw}, {~en0, ~cw0});
    end
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      extra += int'(en_p) + int'(dir_p);
    end
    checks++;
    if (extra !== 0) begin errors++; $display("[TB] FAIL hold_repeat got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid();
    btn_en = 1'b0;
    btn_dir = 1'b0;
    wait_cycles(8);
    btn_dir = 1'b1;
    wait_cycles(4);
    rst = 1'b0;
    #2;
    checks++;
    if (dut_vec !== 6'b100000) begin
      errors++; $display("[TB] FAIL midrst_forced got %b want %b", dut_vec, 6'b100000);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({dir_p, cw} !== {1'(k == 6), 1'(k >= 6)}) begin
        errors++; $display("[TB] FAIL midrst edge %0d got %b want %b", k, {dir_p, cw}, {1'(k == 6), 1'(k >= 6)});
      end
    end
  endtask

  task automatic test_random();
    int hold [2];
    hold[0] = 1;
    hold[1] = 1;
    for (int k = 0; k < 300; k++) begin
      hold[0]--;
      hold[1]--;
      if (hold[0] == 0) begin btn_en = ~btn_en; hold[0] = $urandom_range(1, 8); end
      if (hold[1] == 0) begin btn_dir = ~btn_dir; hold[1] = $urandom_range(1, 8); end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("[TB] FAIL random cycle %0d got %b want %b", k, dut_vec, mdl_vec);
      end
    end
  endtask

  // Overall time limit so a stuck run still reports.
  initial begin
    #100000;
    $display("[TB] FAIL timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "[TB] timeout");
  end

  // Scenario sequence followed by the summary.
  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_release_repress();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
